// File: rtl/shift16_tx_sequencer.sv
// shift16_tx_sequencer: drives an LPM_SHIFTREG's control pins to emit start/data/stop framed serial words
module shift16_tx_sequencer #(
  parameter int   lpm_width  = 16,
  parameter int   BIT_CYCLES = 4,
  parameter int   STOP_BITS  = 1,
  parameter int   GAP_CYCLES = 0,
  parameter logic FILL_BIT   = 1'b0
) (
  input  logic Clock,
  input  logic Sclr,
  input  logic Req,
  output logic Ack,
  output logic Busy,
  output logic Done,
  output logic TxD,
  output logic SR_Load,
  output logic SR_Enable,
  output logic SR_ShiftIn,
  input  logic SR_ShiftOut
);
  localparam int DW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = $clog2(lpm_width);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, START, SHIFT, STOP, GAP} state_t;
  state_t state, state_nx;
  logic [DW-1:0] div_cnt, div_nx;
  logic [BW-1:0] bit_cnt, bit_nx;
  logic stop_cnt, stop_nx;
  logic [GW-1:0] gap_cnt, gap_nx;
  logic div_last, bit_last, stop_last, gap_last;
  assign div_last = div_cnt == DW'(BIT_CYCLES - 1);
  assign bit_last = bit_cnt == BW'(lpm_width - 1);
  assign stop_last = stop_cnt == 1'(STOP_BITS - 1);
  assign gap_last = gap_cnt == GW'(GAP_CYCLES - 1);
  assign Busy = state != IDLE;
  assign SR_ShiftIn = FILL_BIT;
  assign TxD = (state == START) ? 1'b0 : (state == SHIFT) ? SR_ShiftOut : 1'b1;
  // state and counter registers; Sclr abandons any frame in progress
  always_ff @(posedge Clock)
    if (Sclr) begin
      state <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      stop_cnt <= 1'b0;
      gap_cnt <= '0;
    end else begin
      state <= state_nx;
      div_cnt <= div_nx;
      bit_cnt <= bit_nx;
      stop_cnt <= stop_nx;
      gap_cnt <= gap_nx;
    end
  // next-state, counter updates and register control strobes
  always_comb begin
    state_nx = state;
    div_nx = div_cnt;
    bit_nx = bit_cnt;
    stop_nx = stop_cnt;
    gap_nx = gap_cnt;
    Ack = 1'b0;
    Done = 1'b0;
    SR_Load = 1'b0;
    SR_Enable = 1'b0;
    case (state)
      IDLE: if (Req && !Sclr) begin
        Ack = 1'b1;
        SR_Load = 1'b1;
        SR_Enable = 1'b1;
        state_nx = START;
      end
      START: begin
        div_nx = div_last ? '0 : div_cnt + 1'b1;
        if (div_last) state_nx = SHIFT;
      end
      SHIFT: begin
        div_nx = div_last ? '0 : div_cnt + 1'b1;
        if (div_last) begin
          SR_Enable = 1'b1;
          bit_nx = bit_last ? '0 : bit_cnt + 1'b1;
          if (bit_last) state_nx = STOP;
        end
      end
      STOP: begin
        div_nx = div_last ? '0 : div_cnt + 1'b1;
        if (div_last) begin
          stop_nx = stop_last ? 1'b0 : stop_cnt + 1'b1;
          if (stop_last) begin
            Done = 1'b1;
            state_nx = GAP_CYCLES > 0 ? GAP : IDLE;
          end
        end
      end
      GAP: begin
        gap_nx = gap_last ? '0 : gap_cnt + 1'b1;
        if (gap_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule
